// File: rtl/popcount_sched_pkg.sv
// popcount_sched_pkg: shared types and constants for popcount_rr_sched
//   state_t : scheduler FSM states
//   PC_W    : popcount result width for a 32-bit word (0..32)
//   id_w()  : requester id width, clog2(n) with a floor of 1 bit
package popcount_sched_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
   localparam int PC_W = 6;
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/popcount_rr_sched_if.sv
// popcount_rr_sched_if: requester and response bundle for popcount_rr_sched
//   req_valid/req_data/req_last/req_ready : per-requester word stream
//   rsp_valid/rsp_ready/rsp_id/rsp_count/rsp_sat : single result port
//   slave modport is the scheduler side, master the requester/consumer side
interface popcount_rr_sched_if
   import popcount_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int AW   = 12
);
   localparam int IW = id_w(NREQ);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_last;
   logic [NREQ-1:0]    req_ready;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IW-1:0]      rsp_id;
   logic [AW-1:0]      rsp_count;
   logic               rsp_sat;
   modport slave (
      input  req_valid, req_data, req_last, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_count, rsp_sat
   );
   modport master (
      output req_valid, req_data, req_last, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_count, rsp_sat
   );
endinterface

// File: rtl/popcount_tree.sv
// popcount_tree: combinational 32-bit population count
//   a : input word
//   y : number of set bits, 0..32
// Pairwise adder tree with 2/3/4/5/6-bit stages.
module popcount_tree
   import popcount_sched_pkg::*;
(
   input  logic [31:0]     a,
   output logic [PC_W-1:0] y
);
   logic [1:0] s1 [16];
   logic [2:0] s2 [8];
   logic [3:0] s3 [4];
   logic [4:0] s4 [2];
   for (genvar i = 0; i < 16; i++) assign s1[i] = {1'b0, a[2*i]} + {1'b0, a[2*i+1]};
   for (genvar i = 0; i < 8; i++)  assign s2[i] = {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
   for (genvar i = 0; i < 4; i++)  assign s3[i] = {1'b0, s2[2*i]} + {1'b0, s2[2*i+1]};
   for (genvar i = 0; i < 2; i++)  assign s4[i] = {1'b0, s3[2*i]} + {1'b0, s3[2*i+1]};
   assign y = {1'b0, s4[0]} + {1'b0, s4[1]};
endmodule

// File: rtl/popcount_rr_sched.sv
// popcount_rr_sched: round-robin shared popcount accumulator
//   clk, rst : clock and synchronous active-high reset
//   bus      : popcount_rr_sched_if.slave (request streams + response port)
// Optional macro POPCOUNT_SCHED_SAT_EN: clamp the total at 2^AW-1 and flag rsp_sat;
// otherwise the total wraps mod 2^AW and rsp_sat stays 0.
module popcount_rr_sched
   import popcount_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int AW   = 12
)(
   input  logic clk,
   input  logic rst,
   popcount_rr_sched_if.slave bus
);
   localparam int IW = id_w(NREQ);
   state_t          state;
   logic [IW-1:0]   rr_ptr, owner, grant, id_r;
   logic [NREQ-1:0] ready;
   logic [AW-1:0]   acc, nxt, cnt;
   logic [DW-1:0]   word;
   logic [PC_W-1:0] pc;
   logic            fire, ovf, sat_flag, vld, sat_r;
   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      grant = rr_ptr;
      for (int k = NREQ - 1; k >= 0; k--)
         if (bus.req_valid[(int'(rr_ptr) + k) % NREQ]) grant = IW'((int'(rr_ptr) + k) % NREQ);
   end
   assign word = bus.req_data[owner*DW +: DW];
   popcount_tree u_tree (.a(word), .y(pc));
`ifdef POPCOUNT_SCHED_SAT_EN
   logic [AW:0] sum;
   assign sum = {1'b0, acc} + (AW+1)'(pc);
   assign ovf = sum[AW];
   assign nxt = ovf ? '1 : sum[AW-1:0];
`else
   assign ovf = 1'b0;
   assign nxt = acc + AW'(pc);
`endif
   assign fire = (state == BUSY) && bus.req_valid[owner];
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         acc      <= '0;
         sat_flag <= 1'b0;
         ready    <= '0;
         vld      <= 1'b0;
         id_r     <= '0;
         cnt      <= '0;
         sat_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (|bus.req_valid) begin
               owner    <= grant;
               acc      <= '0;
               sat_flag <= 1'b0;
               ready    <= NREQ'(1) << grant;
               state    <= BUSY;
            end
            BUSY: if (fire) begin
               if (bus.req_last[owner]) begin
                  cnt   <= nxt;
                  sat_r <= sat_flag | ovf;
                  id_r  <= owner;
                  vld   <= 1'b1;
                  ready <= '0;
                  state <= HOLD;
               end else begin
                  acc      <= nxt;
                  sat_flag <= sat_flag | ovf;
               end
            end
            HOLD: if (bus.rsp_ready) begin
               vld    <= 1'b0;
               rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.req_ready = ready;
   assign bus.rsp_valid = vld;
   assign bus.rsp_id    = id_r;
   assign bus.rsp_count = cnt;
   assign bus.rsp_sat   = sat_r;
endmodule

// File: tb/tb_popcount_rr_sched.sv
// tb_popcount_rr_sched: directed self-checking bench for popcount_rr_sched
module tb_popcount_rr_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   popcount_rr_sched_if #(.NREQ(4), .DW(32), .AW(12)) b ();
   popcount_rr_sched_if #(.NREQ(4), .DW(32), .AW(6))  s ();
   popcount_rr_sched #(.NREQ(4), .DW(32), .AW(12)) u_dut (.clk(clk), .rst(rst), .bus(b.slave));
   popcount_rr_sched #(.NREQ(4), .DW(32), .AW(6))  u_sat (.clk(clk), .rst(rst), .bus(s.slave));
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      b.req_valid = '0;
      b.req_last = '0;
      s.req_valid = '0;
      s.req_last = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask
   // Present one word, wait (bounded) for ready, let it be accepted, then drop valid.
   task automatic send_word(input int id, input logic [31:0] w, input logic last, output logic ok);
      int k = 0;
      b.req_valid[id] = 1'b1;
      b.req_data[id*32 +: 32] = w;
      b.req_last[id] = last;
      while (!b.req_ready[id] && k < 40) begin
         tick();
         k++;
      end
      ok = b.req_ready[id];
      tick();
      b.req_valid[id] = 1'b0;
      b.req_last[id] = 1'b0;
   endtask
   task automatic test_reset();
      b.req_data = '0;
      s.req_data = '0;
      b.rsp_ready = 1'b0;
      s.rsp_ready = 1'b1;
      do_reset();
      n_chk++; if (b.req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", b.req_ready); end
      n_chk++; if (b.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", b.rsp_valid); end
      n_chk++; if (b.rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got=%0d exp=0", b.rsp_id); end
      n_chk++; if (b.rsp_count !== 12'd0) begin n_fail++; $display("FAIL reset_rsp_count got=%0d exp=0", b.rsp_count); end
      n_chk++; if (b.rsp_sat !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_sat got=%b exp=0", b.rsp_sat); end
   endtask
   task automatic test_single_word();
      logic ok;
      send_word(2, 32'hFFFF_FFFF, 1'b1, ok);
      n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_grant got=%b exp=1", ok); end
      n_chk++; if (b.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency got=%b exp=1", b.rsp_valid); end
      n_chk++; if (b.rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_id got=%0d exp=2", b.rsp_id); end
      n_chk++; if (b.rsp_count !== 12'd32) begin n_fail++; $display("FAIL single_count got=%0d exp=32", b.rsp_count); end
      b.rsp_ready = 1'b1;
      tick();
      n_chk++; if (b.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_consume got=%b exp=0", b.rsp_valid); end
   endtask
   task automatic test_round_robin();
      int exp_id[5] = '{0, 1, 2, 3, 0};
      int exp_cnt[5] = '{0, 1, 2, 16, 3};
      int rec_id[5] = '{-1, -1, -1, -1, -1};
      int rec_cnt[5] = '{-1, -1, -1, -1, -1};
      int got = 0;
      int cyc = 0;
      logic re = 1'b0;
      logic [3:0] mask;
      do_reset();
      b.rsp_ready = 1'b1;
      b.req_data = {32'hF0F0_F0F0, 32'h8000_0001, 32'h0000_0001, 32'h0000_0000};
      b.req_last = 4'b1111;
      b.req_valid = 4'b1111;
      while (got < 5 && cyc < 100) begin
         mask = b.req_valid & b.req_ready;
         if (b.rsp_valid) begin
            rec_id[got] = int'(b.rsp_id);
            rec_cnt[got] = int'(b.rsp_count);
            got++;
         end
         tick();
         cyc++;
         b.req_valid = b.req_valid & ~mask;
         if (got >= 1 && !re) begin
            b.req_data[31:0] = 32'h0000_0007;
            b.req_valid[0] = 1'b1;
            re = 1'b1;
         end
      end
      b.req_last = '0;
      n_chk++; if (got !== 5) begin n_fail++; $display("FAIL rr_timeout got=%0d exp=5 responses", got); end
      for (int i = 0; i < 5; i++) begin
         n_chk++; if (rec_id[i] !== exp_id[i]) begin n_fail++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", i, rec_id[i], exp_id[i]); end
         n_chk++; if (rec_cnt[i] !== exp_cnt[i]) begin n_fail++; $display("FAIL rr_count[%0d] got=%0d exp=%0d", i, rec_cnt[i], exp_cnt[i]); end
      end
   endtask
   task automatic test_stall_gap();
      logic ok;
      b.rsp_ready = 1'b1;
      b.req_data[3*32 +: 32] = 32'h0000_00FF;
      b.req_last[3] = 1'b1;
      b.req_valid[3] = 1'b1;
      send_word(1, 32'hAAAA_AAAA, 1'b0, ok);
      for (int i = 0; i < 2; i++) begin
         tick();
         n_chk++; if (b.req_ready !== 4'b0010) begin n_fail++; $display("FAIL gap_ready[%0d] got=%b exp=0010", i, b.req_ready); end
      end
      send_word(1, 32'hAAAA_AAAA, 1'b0, ok);
      send_word(1, 32'hAAAA_AAAA, 1'b1, ok);
      n_chk++; if (b.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid got=%b exp=1", b.rsp_valid); end
      n_chk++; if (b.rsp_id !== 2'd1) begin n_fail++; $display("FAIL gap_id got=%0d exp=1", b.rsp_id); end
      n_chk++; if (b.rsp_count !== 12'd48) begin n_fail++; $display("FAIL gap_count got=%0d exp=48", b.rsp_count); end
      send_word(3, 32'h0000_00FF, 1'b1, ok);
      n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL gap_next_grant got=%b exp=1", ok); end
      n_chk++; if ({b.rsp_id, b.rsp_count} !== {2'd3, 12'd8}) begin n_fail++; $display("FAIL gap_next id/count got=%0d/%0d exp=3/8", b.rsp_id, b.rsp_count); end
      tick();
   endtask
   task automatic test_hold();
      logic ok;
      b.rsp_ready = 1'b0;
      send_word(2, 32'h0000_FFFF, 1'b1, ok);
      b.req_data[31:0] = 32'h0000_0003;
      b.req_last[0] = 1'b1;
      b.req_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_chk++;
         if ({b.rsp_valid, b.rsp_id, b.rsp_count, b.req_ready} !== {1'b1, 2'd2, 12'd16, 4'b0}) begin
            n_fail++;
            $display("FAIL hold[%0d] got v=%b id=%0d cnt=%0d rdy=%b exp v=1 id=2 cnt=16 rdy=0000", i, b.rsp_valid, b.rsp_id, b.rsp_count, b.req_ready);
         end
      end
      b.rsp_ready = 1'b1;
      tick();
      n_chk++; if ({b.rsp_valid, b.req_ready} !== 5'b0) begin n_fail++; $display("FAIL hold_release got v=%b rdy=%b exp 0/0000", b.rsp_valid, b.req_ready); end
      tick();
      n_chk++; if (b.req_ready !== 4'b0001) begin n_fail++; $display("FAIL hold_regrant got=%b exp=0001", b.req_ready); end
      tick();
      b.req_valid[0] = 1'b0;
      b.req_last[0] = 1'b0;
      n_chk++; if ({b.rsp_valid, b.rsp_id, b.rsp_count} !== {1'b1, 2'd0, 12'd2}) begin n_fail++; $display("FAIL hold_next got v=%b id=%0d cnt=%0d exp 1/0/2", b.rsp_valid, b.rsp_id, b.rsp_count); end
      tick();
   endtask
   task automatic test_reset_mid();
      logic ok;
      logic seen = 1'b0;
      b.rsp_ready = 1'b1;
      send_word(1, 32'hFFFF_FFFF, 1'b0, ok);
      send_word(1, 32'hFFFF_FFFF, 1'b0, ok);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_chk++;
      if ({b.req_ready, b.rsp_valid, b.rsp_id, b.rsp_count, b.rsp_sat} !== 20'b0) begin
         n_fail++;
         $display("FAIL midrst_outputs got rdy=%b v=%b id=%0d cnt=%0d sat=%b exp all 0", b.req_ready, b.rsp_valid, b.rsp_id, b.rsp_count, b.rsp_sat);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         seen = seen | b.rsp_valid;
      end
      n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rsp got=%b exp=0", seen); end
      b.req_data[63:0] = {32'h0000_0003, 32'h0000_0001};
      b.req_last[1:0] = 2'b11;
      b.req_valid[1:0] = 2'b11;
      tick();
      n_chk++; if (b.req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_ptr got=%b exp=0001", b.req_ready); end
      tick();
      b.req_valid[0] = 1'b0;
      n_chk++; if ({b.rsp_id, b.rsp_count} !== {2'd0, 12'd1}) begin n_fail++; $display("FAIL midrst_rsp0 got id=%0d cnt=%0d exp 0/1", b.rsp_id, b.rsp_count); end
      tick();
      tick();
      tick();
      b.req_valid[1] = 1'b0;
      b.req_last = '0;
      n_chk++; if ({b.rsp_valid, b.rsp_id, b.rsp_count} !== {1'b1, 2'd1, 12'd2}) begin n_fail++; $display("FAIL midrst_rsp1 got v=%b id=%0d cnt=%0d exp 1/1/2", b.rsp_valid, b.rsp_id, b.rsp_count); end
      tick();
   endtask
   task automatic test_overflow();
      int k;
      logic to = 1'b0;
`ifdef POPCOUNT_SCHED_SAT_EN
      logic [5:0] exp_cnt = 6'd63;
      logic exp_sat = 1'b1;
`else
      logic [5:0] exp_cnt = 6'd32;
      logic exp_sat = 1'b0;
`endif
      s.rsp_ready = 1'b1;
      s.req_data[31:0] = 32'hFFFF_FFFF;
      for (int w = 0; w < 3; w++) begin
         s.req_valid[0] = 1'b1;
         s.req_last[0] = (w == 2);
         k = 0;
         while (!s.req_ready[0] && k < 40) begin
            tick();
            k++;
         end
         to = to | !s.req_ready[0];
         tick();
      end
      s.req_valid[0] = 1'b0;
      s.req_last[0] = 1'b0;
      n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL ovf_timeout got=%b exp=0", to); end
      n_chk++; if (s.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got=%b exp=1", s.rsp_valid); end
      n_chk++; if (s.rsp_count !== exp_cnt) begin n_fail++; $display("FAIL ovf_count got=%0d exp=%0d", s.rsp_count, exp_cnt); end
      n_chk++; if (s.rsp_sat !== exp_sat) begin n_fail++; $display("FAIL ovf_sat got=%b exp=%b", s.rsp_sat, exp_sat); end
      tick();
   endtask
   initial begin
      b.req_valid = '0;
      b.req_last = '0;
      s.req_valid = '0;
      s.req_last = '0;
      test_reset();
      test_single_word();
      test_round_robin();
      test_stall_gap();
      test_hold();
      test_reset_mid();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
